reg_bank: RTL and testbench

//   Parametrised multi-register bank; generalises the single 32-bit general register.

---
 rtl/reg_bank.sv | 93 +++++++++
 tb/tb_reg_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// Register bank: DEPTH x WIDTH registers, one byte-enabled write port, two registered read ports with write-to-read bypass.
// Define REG_BANK_R0_ZERO_EN to hardwire register 0 to zero.
module reg_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [NB-1:0]    wbe,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    // Post-write value of every register; reading from it yields the bypass for free.
    logic [WIDTH-1:0] post_val [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
`ifdef REG_BANK_R0_ZERO_EN
            if (gi == 0) begin : g_zero
                assign post_val[gi] = '0;
            end else begin : g_store
`else
            begin : g_store
`endif
                logic [WIDTH-1:0] mem_reg;
                logic [WIDTH-1:0] mem_next;

                always_comb begin
                    mem_next = mem_reg;
                    if (we && (waddr == AW'(gi))) begin
                        for (int bi = 0; bi < NB; bi++) begin
                            if (wbe[bi]) begin
                                mem_next[8*bi +: 8] = wdata[8*bi +: 8];
                            end
                        end
                    end
                end

                always_ff @(posedge clk or posedge clr) begin
                    if (clr) begin
                        mem_reg <= '0;
                    end else begin
                        mem_reg <= mem_next;
                    end
                end

                assign post_val[gi] = mem_next;
            end
        end
    endgenerate

    // Out-of-range addresses match no entry and therefore read as zero.
    logic [WIDTH-1:0] rdata_a_next;
    logic [WIDTH-1:0] rdata_b_next;

    always_comb begin
        rdata_a_next = '0;
        rdata_b_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                rdata_a_next = post_val[i];
            end
            if (raddr_b == AW'(i)) begin
                rdata_b_next = post_val[i];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) begin
                rdata_a <= rdata_a_next;
            end
            if (re_b) begin
                rdata_b <= rdata_b_next;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (DEPTH=12 so out-of-range addresses exist).
// Honours REG_BANK_R0_ZERO_EN when the design is built with it.
module tb_reg_bank;

    localparam int WIDTH = 32;
    localparam int DEPTH = 12;
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             we = 1'b0;
    logic [NB-1:0]    wbe = '0;
    logic [AW-1:0]    waddr = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic             re_a = 1'b0;
    logic [AW-1:0]    raddr_a = '0;
    logic [WIDTH-1:0] rdata_a;
    logic             re_b = 1'b0;
    logic [AW-1:0]    raddr_b = '0;
    logic [WIDTH-1:0] rdata_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
    );

    always #5 clk = ~clk;

    // Behavioural model: an array of words plus the two read-port holding registers.
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] exp_a = '0;
    logic [WIDTH-1:0] exp_b = '0;

    function automatic logic [WIDTH-1:0] value_after_edge(int a);
        logic [WIDTH-1:0] v;
        if (a >= DEPTH) return '0;
`ifdef REG_BANK_R0_ZERO_EN
        if (a == 0) return '0;
`endif
        v = m_mem[a];
        if (we && (int'(waddr) == a)) begin
            for (int bi = 0; bi < NB; bi++) begin
                if (wbe[bi]) v[8*bi +: 8] = wdata[8*bi +: 8];
            end
        end
        return v;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            exp_a <= '0;
            exp_b <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= value_after_edge(i);
            if (re_a) exp_a <= value_after_edge(int'(raddr_a));
            if (re_b) exp_b <= value_after_edge(int'(raddr_b));
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (rdata_a !== exp_a) begin
                n_errors++;
                $display("FAIL model_a t=%0t rdata_a=%h expected=%h", $time, rdata_a, exp_a);
            end
            n_checks++;
            if (rdata_b !== exp_b) begin
                n_errors++;
                $display("FAIL model_b t=%0t rdata_b=%h expected=%h", $time, rdata_b, exp_b);
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    // One clock transaction: drive at negedge, return at the next negedge.
    task automatic cycle(input logic w, input logic [NB-1:0] be, input int wa, input logic [WIDTH-1:0] wd,
                         input logic ra_en, input int ra, input logic rb_en, input int rb);
        we = w; wbe = be; waddr = AW'(wa); wdata = wd;
        re_a = ra_en; raddr_a = AW'(ra); re_b = rb_en; raddr_b = AW'(rb);
        @(negedge clk);
        $display("txn t=%0t we=%0b wbe=%h waddr=%0d wdata=%h re_a=%0b ra=%0d re_b=%0b rb=%0d -> a=%h b=%h",
                 $time, w, be, wa, wd, ra_en, ra, rb_en, rb, rdata_a, rdata_b);
    endtask

    logic [WIDTH-1:0] r0_exp;

    initial begin
        #2 clr = 1'b1;
        #1 chk_en = 1'b1;
        #97;
        @(negedge clk);
        clr = 1'b0;

        // Reset state and reads before any write
        cycle(0, 4'h0, 0, 0, 1, 0, 1, 11);
        check("reset_a", rdata_a, 32'h0);
        check("reset_b", rdata_b, 32'h0);

        // Full write then read one cycle later
        cycle(1, 4'hF, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle(0, 4'h0, 0, 0, 1, 3, 0, 0);
        check("write_full", rdata_a, 32'hDEADBEEF);

        // Byte-enabled write
        cycle(1, 4'b0101, 3, 32'h11223344, 0, 0, 0, 0);
        cycle(0, 4'h0, 0, 0, 1, 3, 1, 3);
        check("byte_en_a", rdata_a, 32'hDE22BE44);
        check("byte_en_b", rdata_b, 32'hDE22BE44);

        // Bypass on both ports
        cycle(1, 4'hF, 5, 32'hA5A5A5A5, 1, 5, 1, 5);
        check("bypass_a", rdata_a, 32'hA5A5A5A5);
        check("bypass_b", rdata_b, 32'hA5A5A5A5);

        // Partial bypass: only the top byte comes from wdata
        cycle(1, 4'b1000, 5, 32'h12345678, 1, 5, 1, 3);
        check("bypass_part", rdata_a, 32'h12A5A5A5);
        check("other_port", rdata_b, 32'hDE22BE44);

        // re_a=0 holds while the source register is rewritten
        cycle(1, 4'hF, 3, 32'h0, 0, 3, 0, 0);
        check("hold_a", rdata_a, 32'h12A5A5A5);
        cycle(0, 4'h0, 0, 0, 0, 0, 1, 3);
        check("rewrite_3", rdata_b, 32'h0);

        // we=1 with wbe=0 is a no-op
        cycle(1, 4'h0, 5, 32'hFFFFFFFF, 1, 5, 0, 0);
        check("wbe_zero", rdata_a, 32'h12A5A5A5);

        // Out-of-range write and read, including the same-edge case
        cycle(1, 4'hF, 13, 32'h1, 1, 13, 1, 13);
        check("oob_read_a", rdata_a, 32'h0);
        cycle(0, 4'h0, 0, 0, 1, 5, 1, 1);
        check("oob_no_alias5", rdata_a, 32'h12A5A5A5);
        check("oob_no_alias1", rdata_b, 32'h0);

        // Highest valid register
        cycle(1, 4'hF, 11, 32'hCAFEF00D, 0, 0, 0, 0);
        cycle(0, 4'h0, 0, 0, 1, 11, 0, 0);
        check("last_reg", rdata_a, 32'hCAFEF00D);

        // Register 0 write with bypass
`ifdef REG_BANK_R0_ZERO_EN
        r0_exp = 32'h0;
`else
        r0_exp = 32'hFFFFFFFF;
`endif
        cycle(1, 4'hF, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        check("r0_bypass", rdata_a, r0_exp);
        cycle(0, 4'h0, 0, 0, 0, 0, 1, 0);
        check("r0_read", rdata_b, r0_exp);

        // Asynchronous clear mid-sequence, with a write pending
        cycle(1, 4'hF, 3, 32'h55AA55AA, 1, 3, 1, 11);
        check("pre_clr_a", rdata_a, 32'h55AA55AA);
        we = 1'b1; wbe = 4'hF; waddr = AW'(7); wdata = 32'h77777777;
        re_a = 1'b1; raddr_a = AW'(7); re_b = 1'b1; raddr_b = AW'(7);
        #1 clr = 1'b1;
        #1;
        check("async_clr_a", rdata_a, 32'h0);
        check("async_clr_b", rdata_b, 32'h0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        cycle(0, 4'h0, 0, 0, 1, 3, 1, 7);
        check("clr_reg3", rdata_a, 32'h0);
        check("clr_reg7", rdata_b, 32'h0);
        cycle(0, 4'h0, 0, 0, 1, 11, 0, 0);
        check("clr_reg11", rdata_a, 32'h0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
